// File: rtl/job_arbiter_if.sv
// Requester-side and engine-side handshake bundle for job_arbiter.
interface job_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] cancel;
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic [N-1:0] err;
  logic         eng_go;
  logic         eng_kill;
  logic         eng_done;
  logic         busy;

  modport slave (
    input  req, cancel, eng_done,
    output grant, ack, err, eng_go, eng_kill, busy
  );

  modport master (
    output req, cancel, eng_done,
    input  grant, ack, err, eng_go, eng_kill, busy
  );
endinterface

// File: rtl/job_arbiter.sv
// Round-robin arbiter sharing one go/kill/done engine among N requesters,
// with cancel handling and a saturating watchdog that aborts hung jobs.
module job_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned KILL_HOLD = 2
) (
  input logic          clk,
  input logic          reset,
  job_arbiter_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, KILL, RELEASE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [7:0]     timer_q, timer_d;
  logic [3:0]     kcnt_q, kcnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [N-1:0]   err_q, err_d;
  logic           go_q, go_d;
  logic           kill_q, kill_d;
  logic           busy_q, busy_d;

  logic           found;
  logic [IW-1:0]  pick;
  logic [IW-1:0]  cand;
  int unsigned    idx;

  // Search starts just past the last owner, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx  = (32'(ptr_q) + i) % N;
      cand = IW'(idx);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    kcnt_d  = kcnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    go_d    = 1'b0;
    kill_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d       = pick;
          ptr_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          go_d          = 1'b1;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 8'd1;
        // done wins over a same-cycle cancel or timeout
        if (bus.eng_done) begin
          ack_d[owner_q] = 1'b1;
          state_d        = RELEASE;
        end else if (bus.cancel[owner_q] || timer_q == 8'(TIMEOUT - 1)) begin
          err_d[owner_q] = 1'b1;
          kill_d         = 1'b1;
          kcnt_d         = '0;
          state_d        = KILL;
        end
      end
      KILL: begin
        if (kcnt_q == 4'(KILL_HOLD - 1)) begin
          state_d = RELEASE;
        end else begin
          kill_d = 1'b1;
          kcnt_d = kcnt_q + 4'd1;
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N - 1);
      owner_q <= '0;
      timer_q <= '0;
      kcnt_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      go_q    <= 1'b0;
      kill_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      kcnt_q  <= kcnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      go_q    <= go_d;
      kill_q  <= kill_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.eng_go   = go_q;
  assign bus.eng_kill = kill_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_job_arbiter.sv
// Scoreboard bench for job_arbiter: expected grant/ack/err events are queued as
// stimulus is applied and matched as the arbiter produces them.
module tb_job_arbiter;
  localparam int unsigned N         = 4;
  localparam int unsigned TIMEOUT   = 200;
  localparam int unsigned KILL_HOLD = 2;
  localparam int          DONE_LAT  = 103;

  localparam int EV_GRANT = 0;
  localparam int EV_ACK   = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_KILL  = 3;

  typedef struct {
    int           kind;
    logic [N-1:0] val;
  } ev_t;

  logic clk;
  logic rst_n;
  bit   engine_en;
  int   n_checks;
  int   n_fail;
  int   go_len;
  int   kill_len;
  ev_t  sb[$];

  job_arbiter_if #(.N(N)) bus ();

  job_arbiter #(
    .N(N),
    .TIMEOUT(TIMEOUT),
    .KILL_HOLD(KILL_HOLD)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [N-1:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_event(input int kind, input logic [N-1:0] val);
    ev_t   e;
    string tag;
    tag = (kind == EV_GRANT) ? "sb_grant" : (kind == EV_ACK) ? "sb_ack" : "sb_err";
    if (sb.size() == 0) begin
      check({tag, "_underflow"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check(tag, (32'(kind) << 8) | 32'(val), (32'(e.kind) << 8) | 32'(e.val));
    end
  endtask

  task automatic wait_for(input int which, input int limit, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (which)
        EV_GRANT: seen = bus.eng_go;
        EV_ACK:   seen = (bus.ack != '0);
        EV_ERR:   seen = (bus.err != '0);
        default:  seen = bus.eng_kill;
      endcase
      if (seen) break;
    end
    check(tag, 32'(seen), 1);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.grant, bus.ack, bus.err, bus.eng_go, bus.eng_kill, bus.busy});
  endfunction

  // Engine model: done pulse DONE_LAT cycles after go, dropped by kill or reset.
  initial begin
    bit eng_active;
    int eng_cnt;
    eng_active = 1'b0;
    eng_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.eng_kill) eng_active = 1'b0;
      if (engine_en) begin
        bus.eng_done = 1'b0;
        if (eng_active) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus.eng_done = 1'b1;
            eng_active   = 1'b0;
          end
        end
        if (bus.eng_go && rst_n) begin
          eng_active = 1'b1;
          eng_cnt    = DONE_LAT;
        end
      end
    end
  end

  // Output monitor feeding the scoreboard plus pulse-width and exclusivity checks.
  initial begin
    go_len   = 0;
    kill_len = 0;
    forever begin
      @(negedge clk);
      if (bus.eng_go) begin
        go_len++;
        if (go_len == 1) begin
          sb_event(EV_GRANT, bus.grant);
          check("grant_onehot", 32'($onehot(bus.grant)), 1);
        end
      end else if (go_len != 0) begin
        check("go_len", 32'(go_len), 1);
        go_len = 0;
      end
      if (bus.eng_kill) begin
        kill_len++;
      end else if (kill_len != 0) begin
        check("kill_len", 32'(kill_len), KILL_HOLD);
        kill_len = 0;
      end
      if (bus.ack != '0) sb_event(EV_ACK, bus.ack);
      if (bus.err != '0) sb_event(EV_ERR, bus.err);
      if ((bus.ack | bus.err) != '0) check("ack_err_excl", 32'(bus.ack & bus.err), 0);
    end
  end

  initial begin
    int cnt;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    engine_en    = 1'b1;
    bus.req      = '0;
    bus.cancel   = '0;
    bus.eng_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single completion
    push(EV_GRANT, 4'b0001);
    push(EV_ACK, 4'b0001);
    bus.req = 4'b0001;
    @(negedge clk);
    check("t1_go", 32'(bus.eng_go), 1);
    check("t1_grant", 32'(bus.grant), 4'b0001);
    check("t1_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("t1_go_fall", 32'(bus.eng_go), 0);
    wait_for(EV_ACK, 150, "t1_wait_ack");
    check("t1_grant_at_ack", 32'(bus.grant), 4'b0001);
    bus.req = '0;
    @(negedge clk);
    check("t1_release", 32'({bus.grant, bus.ack, bus.busy}), 0);

    // Fairness from a freshly reset pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(EV_GRANT, 4'b0001); push(EV_ACK, 4'b0001);
    push(EV_GRANT, 4'b0010); push(EV_ACK, 4'b0010);
    push(EV_GRANT, 4'b0100); push(EV_ACK, 4'b0100);
    push(EV_GRANT, 4'b1000); push(EV_ACK, 4'b1000);
    push(EV_GRANT, 4'b0001); push(EV_ACK, 4'b0001);
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_for(EV_ACK, 200, "t2_wait_ack");
      bus.req = bus.req & ~bus.ack;
    end
    wait_for(EV_GRANT, 10, "t2_wait_go3");
    repeat (5) @(negedge clk);
    bus.req[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_for(EV_ACK, 200, "t2_wait_ack_tail");
      bus.req = bus.req & ~bus.ack;
    end
    check("t2_req_drained", 32'(bus.req), 0);
    repeat (3) @(negedge clk);

    // Cancel by owner 2; cancel[1] ignored
    push(EV_GRANT, 4'b0100);
    push(EV_ERR, 4'b0100);
    bus.req = 4'b0100;
    wait_for(EV_GRANT, 10, "t3_wait_go");
    repeat (9) @(negedge clk);
    bus.cancel = 4'b0110;
    @(negedge clk);
    bus.cancel = '0;
    check("t3_err", 32'(bus.err), 4'b0100);
    check("t3_kill_rise", 32'(bus.eng_kill), 1);
    check("t3_no_ack", 32'(bus.ack), 0);
    bus.req = '0;
    @(negedge clk);
    check("t3_kill_hold", 32'({bus.eng_kill, bus.err}), 5'b10000);
    @(negedge clk);
    check("t3_kill_fall", 32'(bus.eng_kill), 0);
    check("t3_grant_in_release", 32'(bus.grant), 4'b0100);
    @(negedge clk);
    check("t3_grant_fall", 32'({bus.grant, bus.busy}), 0);
    repeat (2) @(negedge clk);

    // Watchdog timeout with a silent engine
    engine_en = 1'b0;
    bus.eng_done = 1'b0;
    push(EV_GRANT, 4'b0001);
    push(EV_ERR, 4'b0001);
    bus.req = 4'b0001;
    wait_for(EV_GRANT, 10, "t4_wait_go");
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.eng_kill) break;
    end
    check("t4_timeout_latency", 32'(cnt), TIMEOUT + 1);
    check("t4_err", 32'(bus.err), 4'b0001);
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("t4_idle", 32'(bus.busy), 0);

    // Done and cancel on the same cycle: done wins
    push(EV_GRANT, 4'b0010);
    push(EV_ACK, 4'b0010);
    bus.req = 4'b0010;
    wait_for(EV_GRANT, 10, "t5_wait_go");
    repeat (5) @(negedge clk);
    bus.eng_done = 1'b1;
    bus.cancel   = 4'b0010;
    @(negedge clk);
    bus.eng_done = 1'b0;
    bus.cancel   = '0;
    check("t5_ack", 32'(bus.ack), 4'b0010);
    check("t5_no_err_kill", 32'({bus.err, bus.eng_kill}), 0);
    bus.req = '0;
    @(negedge clk);
    check("t5_after", 32'({bus.err, bus.eng_kill}), 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a job
    engine_en = 1'b1;
    push(EV_GRANT, 4'b1000);
    bus.req = 4'b1000;
    wait_for(EV_GRANT, 10, "t6_wait_go");
    repeat (10) @(negedge clk);
    check("t6_busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", outs(), 0);
    bus.req = 4'b1010;
    repeat (2) @(negedge clk);
    check("t6_held_in_reset", outs(), 0);
    push(EV_GRANT, 4'b0010);
    push(EV_ACK, 4'b0010);
    rst_n = 1'b1;
    wait_for(EV_GRANT, 10, "t6_wait_go2");
    check("t6_first_grant", 32'(bus.grant), 4'b0010);
    bus.req = 4'b0010;
    wait_for(EV_ACK, 200, "t6_wait_ack");
    bus.req = '0;
    repeat (3) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
